// File: rtl/l1a_pkg.sv
// Shared defaults, event record and output-stage state type for the L1A trigger receiver.
package l1a_pkg;

    localparam int L1A_EVID_W      = 24;
    localparam int L1A_BCID_W      = 12;
    localparam int L1A_BC_MAX      = 3564;
    localparam int L1A_DEPTH       = 8;
    localparam int L1A_MIN_SPACING = 3;

    typedef struct packed {
        logic [L1A_EVID_W-1:0] evid;
        logic [L1A_BCID_W-1:0] bcid;
    } l1a_event_t;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

endpackage

// File: rtl/l1a_trigger_receiver_if.sv
// Readout handshake between the trigger receiver (master) and readout logic (slave).
interface l1a_trigger_receiver_if
    import l1a_pkg::*;
#(
    parameter int EVID_W = L1A_EVID_W,
    parameter int BCID_W = L1A_BCID_W
);
    logic              rd_valid;
    logic              rd_ready;
    logic [EVID_W-1:0] rd_evid;
    logic [BCID_W-1:0] rd_bcid;

    modport master (output rd_valid, output rd_evid, output rd_bcid, input rd_ready);
    modport slave  (input rd_valid, input rd_evid, input rd_bcid, output rd_ready);
endinterface

// File: rtl/l1a_event_fifo.sv
// Circular event buffer; pointers carry one extra wrap bit so full and empty differ.
module l1a_event_fifo
    import l1a_pkg::*;
#(
    parameter int  DEPTH   = L1A_DEPTH,
    parameter type entry_t = l1a_event_t
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  entry_t                   push_data_i,
    input  logic                     pop_i,
    output entry_t                   pop_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    entry_t        mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q;
    logic [AW:0]   rd_ptr_q;
    logic          do_push_s;
    logic          do_pop_s;

    assign empty_o    = (wr_ptr_q == rd_ptr_q);
    assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_o    = wr_ptr_q - rd_ptr_q;
    assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];
    assign do_push_s  = push_i && !full_o;
    assign do_pop_s   = pop_i && !empty_o;

    // Pointer update; reset discards everything queued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push_s) wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
            if (do_pop_s)  rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end
    end

    // Storage array, no reset needed: contents are only read behind the pointers.
    always_ff @(posedge clk) begin
        if (do_push_s) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end
endmodule

// File: rtl/l1a_trigger_receiver.sv
// L1A consumer: spacing rule, EVID/BCID tagging, event queue and registered readout head.
module l1a_trigger_receiver
    import l1a_pkg::*;
#(
    parameter int EVID_W      = L1A_EVID_W,
    parameter int BCID_W      = L1A_BCID_W,
    parameter int BC_MAX      = L1A_BC_MAX,
    parameter int DEPTH       = L1A_DEPTH,
    parameter int MIN_SPACING = L1A_MIN_SPACING
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            l1a,
    input  logic                            bc0,
    input  logic                            ecr,
    l1a_trigger_receiver_if.master          rd_if,
    output logic                            busy,
    output logic                            overflow,
    output logic [15:0]                     drop_cnt
);
    localparam int OCC_W = $clog2(DEPTH) + 1;
    localparam int SP_W  = $clog2(MIN_SPACING + 1);

    typedef struct packed {
        logic [EVID_W-1:0] evid;
        logic [BCID_W-1:0] bcid;
    } event_t;

    logic [BCID_W-1:0] bcid_q, bcid_d;
    logic [EVID_W-1:0] evid_q, evid_d, evid_tag_s;
    logic [SP_W-1:0]   spc_q, spc_d;
    logic              overflow_q, overflow_d;
    logic [15:0]       drop_q, drop_d;
    out_state_t        state_q;
    event_t            head_q;
    logic              rd_valid_q;

    logic              pop_hs_s, q_full_s, spacing_ok_s;
    logic              accept_s, reject_s, lost_full_s;
    logic              fifo_pop_s, fifo_full_s, fifo_empty_s;
    logic [OCC_W-1:0]  fifo_count_s, occ_s;
    event_t            fifo_wdata_s, fifo_rdata_s;

    // Occupancy counts the head register so back-pressure reflects every held event.
    assign pop_hs_s     = (state_q == OUT_FULL) && rd_if.rd_ready;
    assign occ_s        = fifo_count_s + {{(OCC_W-1){1'b0}}, (state_q == OUT_FULL)};
    assign q_full_s     = (occ_s >= OCC_W'(DEPTH)) || fifo_full_s;
    assign spacing_ok_s = (spc_q == {SP_W{1'b0}});
    assign fifo_pop_s   = !fifo_empty_s && ((state_q == OUT_EMPTY) || pop_hs_s);
    assign fifo_wdata_s = '{evid: evid_tag_s, bcid: bcid_q};

    // Trigger acceptance and next-state of counters and status.
    always_comb begin
        accept_s    = l1a && spacing_ok_s && (!q_full_s || pop_hs_s);
        reject_s    = l1a && !accept_s;
        lost_full_s = l1a && spacing_ok_s && q_full_s && !pop_hs_s;
        evid_tag_s  = ecr ? {EVID_W{1'b0}} : evid_q;

        if (bc0) begin
            bcid_d = {BCID_W{1'b0}};
        end else if (bcid_q == BCID_W'(BC_MAX - 1)) begin
            bcid_d = {BCID_W{1'b0}};
        end else begin
            bcid_d = bcid_q + {{(BCID_W-1){1'b0}}, 1'b1};
        end

        if (accept_s) begin
            evid_d = evid_tag_s + {{(EVID_W-1){1'b0}}, 1'b1};
        end else if (ecr) begin
            evid_d = {EVID_W{1'b0}};
        end else begin
            evid_d = evid_q;
        end

        if (accept_s) begin
            spc_d = SP_W'(MIN_SPACING - 1);
        end else if (!spacing_ok_s) begin
            spc_d = spc_q - {{(SP_W-1){1'b0}}, 1'b1};
        end else begin
            spc_d = spc_q;
        end

        overflow_d = overflow_q | lost_full_s;

        if (reject_s && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end else begin
            drop_d = drop_q;
        end
    end

    // Counter and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcid_q     <= {BCID_W{1'b0}};
            evid_q     <= {EVID_W{1'b0}};
            spc_q      <= {SP_W{1'b0}};
            overflow_q <= 1'b0;
            drop_q     <= 16'd0;
        end else begin
            bcid_q     <= bcid_d;
            evid_q     <= evid_d;
            spc_q      <= spc_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    // Output stage: head register holds data stable until the handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= OUT_EMPTY;
            head_q     <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            case (state_q)
                OUT_EMPTY: begin
                    if (!fifo_empty_s) begin
                        head_q     <= fifo_rdata_s;
                        state_q    <= OUT_FULL;
                        rd_valid_q <= 1'b1;
                    end
                end
                OUT_FULL: begin
                    if (rd_if.rd_ready) begin
                        if (!fifo_empty_s) begin
                            head_q <= fifo_rdata_s;
                        end else begin
                            state_q    <= OUT_EMPTY;
                            rd_valid_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q    <= OUT_EMPTY;
                    rd_valid_q <= 1'b0;
                end
            endcase
        end
    end

    l1a_event_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (event_t)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (accept_s),
        .push_data_i (fifo_wdata_s),
        .pop_i       (fifo_pop_s),
        .pop_data_o  (fifo_rdata_s),
        .full_o      (fifo_full_s),
        .empty_o     (fifo_empty_s),
        .count_o     (fifo_count_s)
    );

    assign rd_if.rd_valid = rd_valid_q;
    assign rd_if.rd_evid  = head_q.evid;
    assign rd_if.rd_bcid  = head_q.bcid;
    assign busy           = (occ_s >= OCC_W'(DEPTH - 2));
    assign overflow       = overflow_q;
    assign drop_cnt       = drop_q;
endmodule

// File: tb/tb_l1a_trigger_receiver.sv
// Directed bench with a scoreboard queue of expected readout events and a handshake monitor.
module tb_l1a_trigger_receiver;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        l1a = 1'b0;
    logic        bc0 = 1'b0;
    logic        ecr = 1'b0;
    logic        busy;
    logic        overflow;
    logic [15:0] drop_cnt;

    int err_cnt = 0;
    int chk_cnt = 0;
    logic [35:0] exp_q [$];

    l1a_trigger_receiver_if rd_if ();

    l1a_trigger_receiver dut (
        .clk      (clk),
        .rst      (rst),
        .l1a      (l1a),
        .bc0      (bc0),
        .ecr      (ecr),
        .rd_if    (rd_if),
        .busy     (busy),
        .overflow (overflow),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: every handshake must deliver the oldest expected event.
    always @(negedge clk) begin
        if (!rst && rd_if.rd_valid && rd_if.rd_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_event", 32'(rd_if.rd_evid), 32'hFFFF_FFFF);
            end else begin
                logic [35:0] e;
                e = exp_q.pop_front();
                chk("evid", 32'(rd_if.rd_evid), 32'(e[35:12]));
                chk("bcid", 32'(rd_if.rd_bcid), 32'(e[11:0]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        tick();
        rst = 1'b0;
    endtask

    // After this, the current cycle carries BCID 0.
    task automatic sync_bc0();
        bc0 = 1'b1;
        tick();
        bc0 = 1'b0;
    endtask

    task automatic trig(input bit acc, input int evid, input int bcid);
        l1a = 1'b1;
        if (acc) exp_q.push_back({24'(evid), 12'(bcid)});
        tick();
        l1a = 1'b0;
    endtask

    initial begin
        rd_if.rd_ready = 1'b0;
        idle(2);
        chk("reset_rd_valid", 32'(rd_if.rd_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_overflow", 32'(overflow), 32'd0);
        chk("reset_drop_cnt", 32'(drop_cnt), 32'd0);
        rst = 1'b0;

        // Single L1A at BCID 100: valid two edges later, gone after handshake.
        sync_bc0();
        idle(100);
        rd_if.rd_ready = 1'b1;
        trig(1'b1, 0, 100);
        chk("lat_not_yet", 32'(rd_if.rd_valid), 32'd0);
        tick();
        chk("lat_valid", 32'(rd_if.rd_valid), 32'd1);
        tick();
        chk("lat_cleared", 32'(rd_if.rd_valid), 32'd0);

        // Spacing: accept, reject at +1, accept at +3.
        do_reset();
        sync_bc0();
        trig(1'b1, 0, 0);
        trig(1'b0, 0, 0);
        idle(1);
        trig(1'b1, 1, 3);
        chk("spacing_drop", 32'(drop_cnt), 32'd1);
        chk("spacing_ovf", 32'(overflow), 32'd0);
        idle(4);

        // Fill with readout stalled: busy from occupancy 6, ninth is lost.
        do_reset();
        rd_if.rd_ready = 1'b0;
        sync_bc0();
        for (int i = 0; i < 9; i++) begin
            trig(i < 8, i, 3 * i);
            if (i < 8) chk("fill_busy", 32'(busy), 32'(i >= 5));
            idle(2);
        end
        chk("fill_ovf", 32'(overflow), 32'd1);
        chk("fill_drop", 32'(drop_cnt), 32'd1);
        rd_if.rd_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            chk("drain_streaming", 32'(rd_if.rd_valid), 32'd1);
            tick();
        end
        chk("drain_empty", 32'(rd_if.rd_valid), 32'd0);
        chk("drain_ovf_sticky", 32'(overflow), 32'd1);

        // Full queue, L1A coincident with a pop is accepted.
        do_reset();
        rd_if.rd_ready = 1'b0;
        sync_bc0();
        for (int i = 0; i < 8; i++) begin
            trig(1'b1, i, 3 * i);
            idle(2);
        end
        rd_if.rd_ready = 1'b1;
        trig(1'b1, 8, 24);
        rd_if.rd_ready = 1'b0;
        chk("fullpop_ovf", 32'(overflow), 32'd0);
        chk("fullpop_drop", 32'(drop_cnt), 32'd0);
        chk("fullpop_busy", 32'(busy), 32'd1);
        idle(2);
        trig(1'b0, 0, 0);
        chk("fullpop_still_full", 32'(overflow), 32'd1);
        rd_if.rd_ready = 1'b1;
        idle(10);

        // ECR coincident with L1A at EVID 57, then ECR alone.
        do_reset();
        sync_bc0();
        for (int i = 0; i < 57; i++) begin
            trig(1'b1, i, 3 * i);
            idle(2);
        end
        ecr = 1'b1;
        trig(1'b1, 0, 171);
        ecr = 1'b0;
        idle(2);
        trig(1'b1, 1, 174);
        idle(2);
        ecr = 1'b1;
        tick();
        ecr = 1'b0;
        trig(1'b1, 0, 178);
        idle(4);

        // BCID wrap at BC_MAX-1 and bc0 resync at 2000.
        do_reset();
        sync_bc0();
        idle(3563);
        trig(1'b1, 0, 3563);
        idle(2);
        trig(1'b1, 1, 2);
        sync_bc0();
        idle(2000);
        bc0 = 1'b1;
        trig(1'b1, 2, 2000);
        bc0 = 1'b0;
        idle(2);
        trig(1'b1, 3, 2);
        idle(4);

        // Reset during a drain with five queued.
        do_reset();
        rd_if.rd_ready = 1'b0;
        sync_bc0();
        for (int i = 0; i < 5; i++) begin
            trig(1'b1, i, 3 * i);
            if (i == 0) begin
                trig(1'b0, 0, 0);
                idle(1);
            end else begin
                idle(2);
            end
        end
        chk("prerst_valid", 32'(rd_if.rd_valid), 32'd1);
        chk("prerst_drop", 32'(drop_cnt), 32'd1);
        rd_if.rd_ready = 1'b1;
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(rd_if.rd_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_ovf", 32'(overflow), 32'd0);
        chk("midrst_drop", 32'(drop_cnt), 32'd0);
        exp_q.delete();
        tick();
        rst = 1'b0;
        sync_bc0();
        trig(1'b1, 0, 0);
        idle(4);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
